// File: rtl/sine_gen_pkg.sv
// rtl/sine_gen_pkg.sv - shared widths, constants and types for the sine sample generator
package sine_gen_pkg;
  localparam int DEFAULT_PHASE_W    = 16;
  localparam int DEFAULT_LUT_ADDR_W = 6;
  localparam int DEFAULT_SAMPLE_W   = 8;
  localparam int MAG_W              = 7;
  localparam int MIDSCALE           = 128;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_e;

  // The falling half of each half-cycle reads the quarter table backwards.
  function automatic logic mirror_quadrant(input quadrant_e q);
    return (q == Q1) || (q == Q3);
  endfunction
endpackage

// File: rtl/sine_quarter_rom.sv
// rtl/sine_quarter_rom.sv - quarter-wave sine magnitude table, registered read
module sine_quarter_rom
  import sine_gen_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_LUT_ADDR_W
) (
  input  logic              clk_in,
  input  logic [ADDR_W-1:0] addr,
  output logic [MAG_W-1:0]  data
);
  // Entry i = round(127 * sin(pi/2 * (i + 0.5) / 64)); half-step offset keeps zero out of the table.
  localparam logic [MAG_W-1:0] TABLE [2**ADDR_W] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  always_ff @(posedge clk_in) begin
    data <= TABLE[addr];
  end
endmodule

// File: rtl/sine_sample_gen.sv
// rtl/sine_sample_gen.sv - tick-driven phase accumulator with 3-stage quarter-wave sine pipeline
module sine_sample_gen
  import sine_gen_pkg::*;
#(
  parameter int PHASE_W    = DEFAULT_PHASE_W,
  parameter int LUT_ADDR_W = DEFAULT_LUT_ADDR_W,
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                tick_in,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  phase_inc,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun
);
  localparam int IDX_W = LUT_ADDR_W + 2;

  logic                  tick_d;
  logic                  tick_event;
  logic [PHASE_W-1:0]    phase;
  logic                  s0_vld, s1_vld, s2_vld;
  logic [IDX_W-1:0]      s0_idx;
  logic                  s1_neg, s2_neg;
  logic [LUT_ADDR_W-1:0] rom_addr, s1_addr;
  logic [MAG_W-1:0]      rom_data;
  logic [SAMPLE_W-1:0]   mag_ext, sample_next;
  quadrant_e             quad;

  assign tick_event = tick_in & ~tick_d & enable;

  // Only the quadrant and table-index bits of the phase travel down the pipe.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_d <= 1'b0;
      phase  <= '0;
      s0_vld <= 1'b0;
      s0_idx <= '0;
    end else begin
      tick_d <= tick_in;
      s0_vld <= tick_event;
      if (tick_event) begin
        s0_idx <= phase[PHASE_W-1 -: IDX_W];
        phase  <= phase + phase_inc;
      end
    end
  end

  always_comb begin
    quad     = quadrant_e'(s0_idx[IDX_W-1 -: 2]);
    rom_addr = s0_idx[LUT_ADDR_W-1:0];
    if (mirror_quadrant(quad)) begin
      rom_addr = ~s0_idx[LUT_ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s1_neg  <= 1'b0;
      s2_vld  <= 1'b0;
      s2_neg  <= 1'b0;
    end else begin
      s1_vld  <= s0_vld;
      s1_addr <= rom_addr;
      s1_neg  <= s0_idx[IDX_W-1];
      s2_vld  <= s1_vld;
      s2_neg  <= s1_neg;
    end
  end

  sine_quarter_rom #(
    .ADDR_W(LUT_ADDR_W)
  ) u_rom (
    .clk_in(clk_in),
    .addr  (s1_addr),
    .data  (rom_data)
  );

  always_comb begin
    mag_ext     = SAMPLE_W'(rom_data);
    sample_next = s2_neg ? (SAMPLE_W'(MIDSCALE - 1) - mag_ext)
                         : (SAMPLE_W'(MIDSCALE) + mag_ext);
  end

  // A new sample always wins; it only counts as an overrun if the old one was never taken.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sample_out   <= SAMPLE_W'(MIDSCALE);
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (s2_vld) begin
      sample_out   <= sample_next;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end
endmodule

// File: doc/sine_sample_gen.md
SINE_SAMPLE_GEN -- requirements
Module: sine_sample_gen

Interface
REQ-001 SHALL have parameter PHASE_W, 16, phase accumulator width.
REQ-002 SHALL have parameter LUT_ADDR_W, 6, quarter-wave ROM address width (64 entries).
REQ-003 SHALL have parameter SAMPLE_W, 8, output sample width, unsigned offset-binary.
REQ-004 SHALL have port clk_in  input  1  system clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tick_in  input  1  divided-clock level from the clock divider stage (registered in clk_in domain).
REQ-007 SHALL have port enable  input  1  gates tick acceptance.
REQ-008 SHALL have port phase_inc  input  PHASE_W  phase step per accepted tick.
REQ-009 SHALL have port sample_out  output  SAMPLE_W  current sine sample.
REQ-010 SHALL have port sample_valid  output  1  sample_out holds an unconsumed sample.
REQ-011 SHALL have port sample_ready  input  1  downstream accepts the sample on any edge where valid and ready are both 1.
REQ-012 SHALL have port overrun  output  1  sticky flag: unconsumed sample overwritten.

Function
REQ-013 SHALL register tick_in once (tick_d); tick event at edge N = tick_in & ~tick_d & enable sampled at N; a level held high yields exactly one event.
REQ-014 On a tick event at edge N, SHALL capture the pre-increment phase into the pipeline and update phase <= phase + phase_inc modulo 2^PHASE_W; phase_inc sampled only at N.
REQ-015 Stage 1 (edge N+1): quadrant q = phase[MSB:MSB-1], a = next LUT_ADDR_W bits; ROM address = a for q=0,2, = (2^LUT_ADDR_W-1)-a for q=1,3; negate flag = q[1].
REQ-016 Stage 2 (edge N+2): ROM data registered; ROM entry i = round(127*sin(pi/2*(i+0.5)/64)), range 2..127.
REQ-017 Stage 3 (edge N+3): sample_out = 128+mag if negate=0, 127-mag if negate=1; sample_valid = 1 from edge N+3.
REQ-018 Pipeline SHALL be fully pipelined; events on every second clk_in cycle (minimum from REQ-013) SHALL each produce one sample.
REQ-019 sample_valid SHALL clear at an edge where valid=1 and ready=1 and no new sample loads at that edge.
REQ-020 When a new sample loads while valid=1 and ready=0, sample_out SHALL take the new value, valid stays 1, overrun SHALL set.
REQ-021 When a new sample loads at the same edge where valid=1 and ready=1, the old sample counts as consumed; valid stays 1; no overrun.
REQ-022 enable=0 SHALL block new events and freeze phase; in-flight stages SHALL complete normally.
REQ-023 overrun SHALL be cleared only by reset.

Reset
REQ-024 reset SHALL asynchronously force phase=0, tick_d=0, all pipeline valid bits=0, sample_out=128, sample_valid=0, overrun=0, including mid-pipeline; in-flight samples are discarded.
REQ-025 First event after reset SHALL use phase 0.

Structure
REQ-026 Package sine_gen_pkg SHALL hold PHASE_W/LUT_ADDR_W/SAMPLE_W defaults, MIDSCALE=128, and a quadrant enum (Q0..Q3).
REQ-027 Quarter-wave table SHALL be sub-module sine_quarter_rom (registered output, one-cycle read latency, synthesizable constant table).

Verification
REQ-028 phase_inc=0x4000, enable=1, four ticks -> sample_out 130, 255, 125, 0; each valid exactly 3 cycles after the event edge.
REQ-029 sample_ready=0, two ticks -> second sample replaces first, overrun=1, valid stays 1; ready=1 for one cycle -> valid=0, overrun remains 1.
REQ-030 tick_in held high 10 cycles -> exactly one sample; enable=0 with ticks -> no samples, phase unchanged.
REQ-031 phase_inc=0xFFFF, three ticks -> captured phases 0x0000, 0xFFFF, 0xFFFE (wrap checked); outputs 130, 127-2=125, 125.
REQ-032 reset asserted at N+2 of an event -> sample_out=128, valid=0 immediately; no sample emerges afterwards.
REQ-033 ticks every 2 cycles, ready=1 -> one sample per event, no overrun, no loss.
